// File: rtl/video_mode_ctl.sv
// Frame-synchronous video mode shadowing plus per-line fetch sequencer (phase, column, quota, DRAM address).
// Latency: mode commits 1 cycle after frame_start; fetch_stb/addr/sel/bsl are registered, 1 cycle after the fetch condition.
// Backpressure: none; fetches are paced purely by c3 and the committed mode, and stop once the line quota is reached.
module video_mode_ctl #(
  parameter int PAGE_W = 8,
  parameter int COL_W  = 8,
  parameter int FC_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                c3,
  input  logic                f1,
  input  logic [7:0]          vconf_in,
  input  logic [PAGE_W-1:0]   vpage_in,
  input  logic                frame_start,
  input  logic                pix_start,
  input  logic [8:0]          cnt_row,
  input  logic [15:0]         txt_char,
  output logic [7:0]          vconf_act,
  output logic [PAGE_W-1:0]   vpage_act,
  output logic [1:0]          render_mode,
  output logic                tv_hires,
  output logic                pix_stb,
  output logic                fetch_stb,
  output logic [3:0]          fetch_sel,
  output logic [1:0]          fetch_bsl,
  output logic [PAGE_W+12:0]  video_addr,
  output logic [4:0]          video_bw,
  output logic                fetch_done,
  output logic [COL_W-1:0]    cnt_col
);

  localparam int AW = PAGE_W + 13;

  typedef enum logic [1:0] {
    VM_ZX   = 2'd0,
    VM_16C  = 2'd1,
    VM_256C = 2'd2,
    VM_TEXT = 2'd3
  } vmod_e;

  // Bandwidth code for a given video mode.
  function automatic logic [4:0] bw_of(input logic [1:0] m);
    case (m)
      2'd0:    bw_of = 5'b11001;
      2'd1:    bw_of = 5'b01001;
      2'd2:    bw_of = 5'b00001;
      default: bw_of = 5'b11100;
    endcase
  endfunction

  logic [7:0]        vconf_q;
  logic [PAGE_W-1:0] vpage_q;
  logic [4:0]        bw_q;
  logic [FC_W-1:0]   fc_q, fc_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [7:0]        quota_q, quota_d;
  logic              fetching_q, fetching_d;
  logic              done_q, done_d;
  logic              stb_q, stb_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [1:0]        bsl_q, bsl_d;

  vmod_e             vmod;
  logic [1:0]        rres;
  logic              per_hit;
  logic [7:0]        quota_lim;
  logic              fetch;
  logic [COL_W-1:0]  col_cur;
  logic [7:0]        quota_cur;
  logic              c_post;
  logic [AW-1:0]     fa;
  logic [3:0]        fsel;
  logic [1:0]        fbsl;

  assign vmod = vmod_e'(vconf_q[1:0]);
  assign rres = vconf_q[7:6];

  // Shadow registers: mode/page only change at a frame boundary so a line never tears.
  // The bandwidth code is captured alongside so it is 0 until the first commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vconf_q <= '0;
      vpage_q <= '0;
      bw_q    <= '0;
    end else if (frame_start) begin
      vconf_q <= vconf_in;
      vpage_q <= vpage_in;
      bw_q    <= bw_of(vconf_in[1:0]);
    end
  end

  // Mode decode: fetch period hit on the phase counter and the per-line fetch quota.
  always_comb begin
    per_hit   = 1'b0;
    quota_lim = 8'd16;
    case (vmod)
      VM_16C: begin
        per_hit = &fc_q[1:0];
        case (rres)
          2'd0:    quota_lim = 8'd64;
          2'd3:    quota_lim = 8'd90;
          default: quota_lim = 8'd80;
        endcase
      end
      VM_256C: begin
        per_hit = fc_q[0];
        case (rres)
          2'd0:    quota_lim = 8'd128;
          2'd3:    quota_lim = 8'd180;
          default: quota_lim = 8'd160;
        endcase
      end
      default: begin
        per_hit = &fc_q[3:0];
        case (rres)
          2'd0:    quota_lim = 8'd16;
          2'd3:    quota_lim = 8'd23;
          default: quota_lim = 8'd20;
        endcase
      end
    endcase
  end

  // Address / lane-select / byte-swap for the column being fetched (pix_start restarts at column 0).
  always_comb begin
    col_cur = pix_start ? '0 : col_q;
    c_post  = ~col_cur[0];
    fa      = '0;
    fsel    = 4'b0011;
    fbsl    = 2'b10;
    case (vmod)
      VM_ZX: begin
        fa   = {vpage_q, 1'b0,
                col_cur[0] ? {3'b110, cnt_row[7:3], col_cur[4:1]}
                           : {cnt_row[7:6], cnt_row[2:0], cnt_row[5:3], col_cur[4:1]}};
        fsel = {~c_post, ~c_post, c_post, c_post};
      end
      VM_16C: begin
        fa   = {vpage_q[PAGE_W-1:3], cnt_row, col_cur[6:0]};
        fsel = {~c_post, ~c_post, 2'b11};
      end
      VM_256C: begin
        fa   = {vpage_q[PAGE_W-1:4], cnt_row, col_cur[7:0]};
        fsel = {~c_post, ~c_post, 2'b11};
      end
      default: begin
        case (col_cur[1:0])
          2'd0: begin
            fa   = {vpage_q[PAGE_W-1:1], vpage_q[0], cnt_row[8:3], 1'b0, col_cur[7:2]};
            fsel = 4'b0011;
          end
          2'd1: begin
            fa   = {vpage_q[PAGE_W-1:1], vpage_q[0], cnt_row[8:3], 1'b1, col_cur[7:2]};
            fsel = 4'b1100;
          end
          2'd2: begin
            fa   = {vpage_q[PAGE_W-1:1], ~vpage_q[0], 3'b000, txt_char[7:0], cnt_row[2:1]};
            fsel = 4'b0001;
            fbsl = {2{cnt_row[0]}};
          end
          default: begin
            fa   = {vpage_q[PAGE_W-1:1], ~vpage_q[0], 3'b000, txt_char[15:8], cnt_row[2:1]};
            fsel = 4'b0010;
            fbsl = {2{cnt_row[0]}};
          end
        endcase
      end
    endcase
  end

  // Fetch sequencer next state: phase counter, column, quota and the fetching/done flags.
  always_comb begin
    fetch      = c3 && (pix_start || (fetching_q && per_hit));
    quota_cur  = pix_start ? 8'd0 : quota_q;
    fc_d       = fc_q;
    col_d      = col_cur;
    quota_d    = quota_cur;
    fetching_d = pix_start | fetching_q;
    done_d     = pix_start ? 1'b0 : done_q;
    stb_d      = fetch;
    addr_d     = addr_q;
    sel_d      = sel_q;
    bsl_d      = bsl_q;
    if (pix_start) begin
      fc_d = '0;
    end else if (c3 && fetching_q) begin
      fc_d = fc_q + FC_W'(1);
    end
    if (fetch) begin
      col_d   = col_cur + COL_W'(1);
      quota_d = quota_cur + 8'd1;
      addr_d  = fa;
      sel_d   = fsel;
      bsl_d   = fbsl;
      if (quota_d == quota_lim) begin
        done_d     = 1'b1;
        fetching_d = 1'b0;
      end
    end
  end

  // Fetch sequencer registers; reset wins over any line in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q       <= '0;
      col_q      <= '0;
      quota_q    <= '0;
      fetching_q <= 1'b0;
      done_q     <= 1'b0;
      stb_q      <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      bsl_q      <= '0;
    end else begin
      fc_q       <= fc_d;
      col_q      <= col_d;
      quota_q    <= quota_d;
      fetching_q <= fetching_d;
      done_q     <= done_d;
      stb_q      <= stb_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      bsl_q      <= bsl_d;
    end
  end

  assign vconf_act   = vconf_q;
  assign vpage_act   = vpage_q;
  assign render_mode = vconf_q[1:0];
  assign tv_hires    = (vmod == VM_TEXT);
  assign pix_stb     = tv_hires ? f1 : c3;
  assign fetch_stb   = stb_q;
  assign fetch_sel   = sel_q;
  assign fetch_bsl   = bsl_q;
  assign video_addr  = addr_q;
  assign video_bw    = bw_q;
  assign fetch_done  = done_q;
  assign cnt_col     = col_q;

endmodule
